// File: rtl/ahb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_arb_pkg
// Purpose  : Shared AHB-Lite transfer codes and arbiter FSM state encoding.
// Revision : 1.0
// ============================================================================
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant; on a tie the requester not served last wins.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ahb_rr_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : ahb_rr_master_arb
// Purpose  : Two-requester round-robin front end driving single AHB-Lite NONSEQ transfers.
// Revision : 1.0
// ============================================================================
module ahb_rr_master_arb
   import ahb_arb_pkg::*;
#(
   parameter int REGWIDTH   = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              req_valid,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*REGWIDTH-1:0]   req_wdata,
   output logic [1:0]              req_ready,
   output logic [1:0]              rsp_valid,
   output logic [REGWIDTH-1:0]     rsp_rdata,
   output logic                    rsp_err,
   output logic                    m_ahb_hsel,
   output logic                    m_ahb_hwrite,
   output logic [1:0]              m_ahb_htrans,
   output logic [2:0]              m_ahb_hsize,
   output logic [ADDR_WIDTH-1:0]   m_ahb_haddr,
   output logic [REGWIDTH-1:0]     m_ahb_hwdata,
   input  logic                    m_ahb_hready,
   input  logic [REGWIDTH-1:0]     m_ahb_hrdata,
   input  logic                    m_ahb_hresp,
   output logic                    timeout_sticky
);

   localparam int              CW        = $clog2(TIMEOUT + 1);
   localparam logic [2:0]      HSIZE     = 3'($clog2(REGWIDTH / 8));
   localparam logic [CW-1:0]   WAIT_LAST = CW'(TIMEOUT - 1);

   arb_state_e            r_state;
   arb_state_e            w_state_nxt;
   logic                  r_last_grant;
   logic [1:0]            w_grant;
   logic                  w_accept;
   logic                  r_gnt_idx;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [REGWIDTH-1:0]   r_wdata;
   logic [CW-1:0]         r_wait_cnt;
   logic                  w_wait_limit;
   logic                  w_done;
   logic                  w_tmo;
   logic [1:0]            r_rsp_valid;
   logic [REGWIDTH-1:0]   r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_tmo_sticky;

   rr_arb2 u_rr_arb2 (
      .valid      (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_grant)
   );

   assign req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : 2'b00;
   assign w_accept  = |(req_valid & req_ready);

   // The final low-hready cycle is the one that would take the count to TIMEOUT.
   assign w_wait_limit = !m_ahb_hready && (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_done       = 1'b0;
      w_tmo        = 1'b0;
      m_ahb_hsel   = 1'b0;
      m_ahb_htrans = HTRANS_IDLE;
      m_ahb_haddr  = '0;
      m_ahb_hwrite = 1'b0;
      m_ahb_hsize  = 3'd0;
      m_ahb_hwdata = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_ADDR;
         end
         ST_ADDR: begin
            m_ahb_hsel   = 1'b1;
            m_ahb_htrans = HTRANS_NONSEQ;
            m_ahb_haddr  = r_addr;
            m_ahb_hwrite = r_write;
            m_ahb_hsize  = HSIZE;
            if (m_ahb_hready) begin
               w_state_nxt = ST_DATA;
            end else if (w_wait_limit) begin
               w_state_nxt = ST_IDLE;
               w_tmo       = 1'b1;
            end
         end
         ST_DATA: begin
            m_ahb_hwdata = r_write ? r_wdata : '0;
            if (m_ahb_hready) begin
               w_state_nxt = ST_IDLE;
               w_done      = 1'b1;
            end else if (w_wait_limit) begin
               w_state_nxt = ST_IDLE;
               w_tmo       = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
         r_gnt_idx    <= 1'b0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
      end else if (w_accept) begin
         r_last_grant <= w_grant[1];
         r_gnt_idx    <= w_grant[1];
         r_write      <= w_grant[1] ? req_write[1] : req_write[0];
         r_addr       <= w_grant[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
         r_wdata      <= w_grant[1] ? req_wdata[2*REGWIDTH-1:REGWIDTH] : req_wdata[REGWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wait_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_wait_cnt <= '0;
      end else if ((r_state != ST_IDLE) && !m_ahb_hready) begin
         r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

   // Watchdog completions report an error with zeroed data regardless of hresp.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid  <= 2'b00;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
         r_tmo_sticky <= 1'b0;
      end else begin
         r_rsp_valid <= 2'b00;
         if (w_done || w_tmo) begin
            r_rsp_valid <= r_gnt_idx ? 2'b10 : 2'b01;
            r_rsp_err   <= w_tmo | m_ahb_hresp;
            r_rsp_rdata <= (w_tmo || r_write) ? '0 : m_ahb_hrdata;
         end
         if (w_tmo) r_tmo_sticky <= 1'b1;
      end
   end

   assign rsp_valid      = r_rsp_valid;
   assign rsp_rdata      = r_rsp_rdata;
   assign rsp_err        = r_rsp_err;
   assign timeout_sticky = r_tmo_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_rr_master_arb
// Purpose  : Directed scoreboard bench for the two-way AHB-Lite master arbiter.
// Revision : 1.0
// ============================================================================
module tb_ahb_rr_master_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [31:0] rsp_rdata, hwdata, hrdata;
   logic        rsp_err, hsel, hwrite, hready, hresp, sticky;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [7:0]  haddr;

   typedef struct {
      logic [1:0]  vld;
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;

   int          aw, dw, ph, s_cnt;
   bit          stuck, s_resp, last_rdy;
   logic [31:0] s_rdata;

   ahb_rr_master_arb #(.REGWIDTH(32), .ADDR_WIDTH(8), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_ahb_hsel(hsel), .m_ahb_hwrite(hwrite), .m_ahb_htrans(htrans), .m_ahb_hsize(hsize),
      .m_ahb_haddr(haddr), .m_ahb_hwdata(hwdata), .m_ahb_hready(hready), .m_ahb_hrdata(hrdata),
      .m_ahb_hresp(hresp), .timeout_sticky(sticky)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Slave: phase tracked from bus outputs, wait states set per test
   initial begin
      ph = 0; s_cnt = 0; last_rdy = 1'b1;
      hready = 1'b1; hrdata = '0; hresp = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ph = 0; s_cnt = 0;
         end else if (hsel) begin
            if (ph != 1) begin ph = 1; s_cnt = 0; end
         end else if (ph == 1 && last_rdy) begin
            ph = 2; s_cnt = 0;
         end else if (ph == 1) begin
            ph = 0;
         end else if (ph == 2 && last_rdy) begin
            ph = 0;
         end
         if (stuck)        hready = 1'b0;
         else if (ph == 1) hready = (s_cnt >= aw);
         else if (ph == 2) hready = (s_cnt >= dw);
         else              hready = 1'b1;
         if (ph != 0 && !hready) s_cnt++;
         hrdata   = s_rdata;
         hresp    = (ph == 2) ? s_resp : 1'b0;
         last_rdy = hready;
      end
   end

   // Monitor: every rsp_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rsp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, e.vld});
            chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rd});
            chk("rsp_err",   {63'd0, rsp_err},   {63'd0, e.err});
            chk("rsp_cycle", 64'(cyc),           64'(e.cyc));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int idx, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err, input int lat, input bit expect_rsp);
      int n = 0;
      req_valid[idx]        = 1'b1;
      req_write[idx]        = wr;
      req_addr[idx*8 +: 8]  = a;
      req_wdata[idx*32 +: 32] = d;
      #1;
      while (!req_ready[idx] && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
         chk("accept_timeout", {62'd0, req_ready}, 64'(1 << idx));
      end else if (expect_rsp) begin
         sb.push_back('{vld: 2'(1 << idx), rd: exp_rd, err: exp_err, cyc: cyc + 1 + lat});
      end
      @(negedge clk);
      req_valid[idx] = 1'b0;
   endtask

   initial begin
      int          prev, k;
      logic [1:0]  want;
      rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      aw = 0; dw = 0; stuck = 1'b0; s_resp = 1'b0; s_rdata = 32'hCAFEF00D;
      repeat (3) @(negedge clk);
      req_valid = 2'b11;
      #1;
      chk("reset_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_bus", {hsel, htrans, haddr, hwrite, hsize, hwdata}, 64'd0);
      chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata, sticky}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Both requesters held valid from reset: grants alternate 3 edges apart
      prev = -1; k = 0;
      for (int i = 0; i < 16 && k < 4; i++) begin
         #1;
         if (req_ready != 2'b00) begin
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("alt_grant", {62'd0, req_ready}, {62'd0, want});
            if (prev >= 0) chk("alt_spacing", 64'(cyc + 1 - prev), 64'd3);
            prev = cyc + 1;
            sb.push_back('{vld: req_ready, rd: 32'hCAFEF00D, err: 1'b0, cyc: cyc + 3});
            k++;
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      chk("alt_count", 64'(k), 64'd4);
      repeat (4) @(negedge clk);

      // Req0 zero-wait read
      s_rdata = 32'hDEADBEEF;
      send(0, 1'b0, 8'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
      chk("rd_addr_phase", {hsel, htrans, haddr, hwrite, hsize}, {1'b1, 2'b10, 8'h04, 1'b0, 3'd2});
      @(negedge clk);
      chk("rd_data_phase", {hsel, htrans, hwdata}, 64'd0);
      repeat (3) @(negedge clk);

      // Req1 write with two DATA wait states; slave drives junk hrdata
      s_rdata = 32'hFFFF0000; dw = 2;
      send(1, 1'b1, 8'h08, 32'h12345678, 32'h0, 1'b0, 4, 1'b1);
      chk("wr_addr_phase", {hsel, htrans, haddr, hwrite}, {1'b1, 2'b10, 8'h08, 1'b1});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("wr_hwdata", {hsel, htrans, hwdata}, {1'b0, 2'b00, 32'h12345678});
      end
      @(negedge clk);
      chk("wr_hwdata_after", {32'd0, hwdata}, 64'd0);
      dw = 0;
      repeat (2) @(negedge clk);

      // Error response, then a back-to-back transfer proves the FSM returned to IDLE
      s_resp = 1'b1; s_rdata = 32'h11112222;
      send(0, 1'b0, 8'h10, 32'h0, 32'h11112222, 1'b1, 2, 1'b1);
      repeat (2) @(negedge clk);
      s_resp = 1'b0;
      send(1, 1'b0, 8'h20, 32'h0, 32'h11112222, 1'b0, 2, 1'b1);
      repeat (3) @(negedge clk);

      // Watchdog with hready stuck low
      chk("sticky_before", {63'd0, sticky}, 64'd0);
      stuck = 1'b1;
      send(1, 1'b0, 8'h30, 32'h0, 32'h0, 1'b1, 4, 1'b1);
      repeat (5) @(negedge clk);
      chk("sticky_set", {63'd0, sticky}, 64'd1);
      stuck = 1'b0;
      send(0, 1'b1, 8'h34, 32'hAAAA5555, 32'h0, 1'b0, 2, 1'b1);
      repeat (3) @(negedge clk);
      chk("sticky_held", {63'd0, sticky}, 64'd1);

      // Reset during DATA wait: transfer abandoned, no response
      dw = 5;
      send(0, 1'b0, 8'h40, 32'h0, 32'h0, 1'b0, 0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0; req_valid = 2'b11;
      #1;
      chk("rst_ready_low", {62'd0, req_ready}, 64'd0);
      @(negedge clk);
      chk("rst_mid_bus", {hsel, htrans, haddr, hwrite, hsize, hwdata}, 64'd0);
      chk("rst_mid_rsp", {rsp_valid, rsp_err, rsp_rdata, sticky}, 64'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_last_grant", {62'd0, req_ready}, 64'd1);
      req_valid = 2'b00; dw = 0;
      repeat (4) @(negedge clk);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
`default_nettype wire
